// File: rtl/am2901_microseq.sv
// Microprogram sequencer for an Am2901 slice: pipelined 32-bit microword fetch,
// flag-conditioned branching, 4-deep subroutine stack, loop counter and halt/resume.
module am2901_microseq (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic [8:0]  alu_i,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic        alu_z,
  input  logic        alu_ovr,
  input  logic        alu_cout,
  input  logic        run,
  output logic        halted,
  output logic        stk_err
);

  typedef enum logic [3:0] {
    OP_CONT = 4'd0,
    OP_JMP  = 4'd1,
    OP_CJS  = 4'd2,
    OP_RTN  = 4'd3,
    OP_RPCT = 4'd4,
    OP_LDCT = 4'd5,
    OP_JZ   = 4'd6,
    OP_HALT = 4'd7
  } op_e;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [6:0] d;
    logic       sen;
    logic       cinv;
    logic [1:0] csel;
    logic [3:0] op;
    logic [3:0] b;
    logic [3:0] a;
    logic [8:0] i;
  } uword_t;

  state_e     r_state;
  uword_t     r_pipe;
  logic [6:0] r_addr;
  logic [6:0] r_cnt;
  logic [2:0] r_sp;
  logic [6:0] r_stack [4];
  logic       r_z, r_c, r_v;
  logic       r_stk_err;

  state_e     w_state_nxt;
  logic [6:0] w_addr_inc;
  logic [6:0] w_addr_nxt;
  logic [6:0] w_cnt_nxt;
  logic [2:0] w_sp_nxt;
  logic [2:0] w_sp_dec;
  logic       w_err_nxt;
  logic       w_push;
  logic       w_fetch;
  logic       w_cond;
  logic       w_flag;

  assign w_addr_inc = r_addr + 7'd1;
  assign w_sp_dec   = r_sp - 3'd1;
  assign w_fetch    = (r_state == S_RUN) || run;

  // Branches test the latched status of an earlier word, never the live flags.
  always_comb begin
    w_flag = 1'b1;
    case (r_pipe.csel)
      2'd0: w_flag = 1'b1;
      2'd1: w_flag = r_z;
      2'd2: w_flag = r_c;
      2'd3: w_flag = r_v;
      default: w_flag = 1'b1;
    endcase
    w_cond = w_flag ^ r_pipe.cinv;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = w_addr_inc;
    w_cnt_nxt   = r_cnt;
    w_sp_nxt    = r_sp;
    w_err_nxt   = r_stk_err;
    w_push      = 1'b0;
    if (r_state == S_RUN) begin
      case (op_e'(r_pipe.op))
        OP_JMP: begin
          if (w_cond) w_addr_nxt = r_pipe.d;
        end
        OP_CJS: begin
          if (w_cond) begin
            w_addr_nxt = r_pipe.d;
            if (r_sp == 3'd4) begin
              w_err_nxt = 1'b1;
            end else begin
              w_push   = 1'b1;
              w_sp_nxt = r_sp + 3'd1;
            end
          end
        end
        OP_RTN: begin
          if (w_cond) begin
            if (r_sp == 3'd0) begin
              w_addr_nxt = 7'd0;
              w_err_nxt  = 1'b1;
            end else begin
              w_addr_nxt = r_stack[w_sp_dec[1:0]];
              w_sp_nxt   = w_sp_dec;
            end
          end
        end
        OP_RPCT: begin
          if (r_cnt != 7'd0) begin
            w_addr_nxt = r_pipe.d;
            w_cnt_nxt  = r_cnt - 7'd1;
          end
        end
        OP_LDCT: w_cnt_nxt = r_pipe.d;
        OP_JZ: begin
          w_addr_nxt = 7'd0;
          w_sp_nxt   = 3'd0;
          w_err_nxt  = 1'b0;
        end
        OP_HALT: w_state_nxt = S_HALT;
        default: ;
      endcase
    end else begin
      // Leaving HALT is a plain fetch; the frozen pipe word's op is not re-run.
      w_addr_nxt = run ? w_addr_inc : r_addr;
      if (run) w_state_nxt = S_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_addr    <= 7'd0;
      r_pipe    <= uword_t'(32'h0000_0040);
      r_cnt     <= 7'd0;
      r_sp      <= 3'd0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_stk_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sp      <= w_sp_nxt;
      r_stk_err <= w_err_nxt;
      if (w_fetch) begin
        r_pipe <= uword_t'(rom_data);
        r_addr <= w_addr_nxt;
      end
      if (r_state == S_RUN && r_pipe.sen) begin
        r_z <= alu_z;
        r_c <= alu_cout;
        r_v <= alu_ovr;
      end
    end
  end

  // NOTE: stack storage has no reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[1:0]] <= w_addr_inc;
  end

  assign rom_addr = r_addr;
  assign halted   = (r_state == S_HALT);
  assign alu_i    = halted ? {3'b001, r_pipe.i[5:0]} : r_pipe.i;
  assign alu_a    = r_pipe.a;
  assign alu_b    = r_pipe.b;
  assign stk_err  = r_stk_err;

endmodule
